// File: rtl/dbus_pkg.sv
// Shared constants, region type and load-alignment helper for the data-side bus controller.
package dbus_pkg;

  // RamMode bit positions: {byte, half, word, unsigned}
  localparam int unsigned ModeByte     = 3;
  localparam int unsigned ModeHalf     = 2;
  localparam int unsigned ModeWord     = 1;
  localparam int unsigned ModeUnsigned = 0;

  typedef enum logic {
    REG_RAM  = 1'b0,
    REG_UART = 1'b1
  } regionT;

  // UART register offsets within the region
  localparam logic [3:0] TXDATA = 4'h0;
  localparam logic [3:0] STATUS = 4'h4;

  // STATUS register bit positions
  localparam int unsigned StatFull     = 0;
  localparam int unsigned StatEmpty    = 1;
  localparam int unsigned StatMisalign = 2;
  localparam int unsigned StatOverflow = 3;

  function automatic logic [31:0] alignLoad(input logic [31:0] word, input logic [1:0] lane,
                                            input logic isByte, input logic isHalf,
                                            input logic isUnsigned);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = 16'(word >> {lane[1], 4'b0000});
    if (isByte) begin
      return isUnsigned ? {24'b0, b} : {{24{b[7]}}, b};
    end else if (isHalf) begin
      return isUnsigned ? {16'b0, h} : {{16{h[15]}}, h};
    end
    return word;
  endfunction

endpackage

// File: rtl/dbus_tx_fifo.sv
// UART transmit FIFO, DEPTH x 8 bits; pointers carry an extra wrap bit to tell full from empty.
module dbus_tx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rstB,
  input  logic       push,
  input  logic [7:0] pushData,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wrPtrQ;
  logic [AW:0] rdPtrQ;
  logic        popOk;
  logic        pushOk;

  assign empty  = (wrPtrQ == rdPtrQ);
  assign full   = (wrPtrQ[AW] != rdPtrQ[AW]) && (wrPtrQ[AW-1:0] == rdPtrQ[AW-1:0]);
  assign popOk  = pop & ~empty;
  // A pop in the same cycle frees the slot the push is about to overwrite.
  assign pushOk = push & (~full | popOk);
  assign head   = empty ? 8'h00 : mem[rdPtrQ[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstB) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
    end else begin
      if (pushOk) wrPtrQ <= wrPtrQ + 1'b1;
      if (popOk)  rdPtrQ <= rdPtrQ + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtrQ[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/data_bus_ctrl.sv
// Data-side bus controller: RAM/UART decode, store lane replication, load align/extend, UART TX.
// Define DBUS_MISALIGN_CHECK_EN to enable alignment checking and the sticky err_misalign flag.
module data_bus_ctrl
  import dbus_pkg::*;
#(
  parameter int unsigned RAM_AW     = 12,
  parameter logic [31:0] UART_BASE  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rstB,
  input  logic              clkEn,
  input  logic [31:0]       addr,
  input  logic [31:0]       dataBusOut,
  input  logic              wrEn,
  input  logic              rdEn,
  input  logic [3:0]        RamMode,
  output logic [31:0]       dataBusIn,
  output logic              dataBusInEn,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_be,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              err_misalign
);

  logic        isByte;
  logic        isHalf;
  logic        isUnsigned;
  logic        aligned;
  logic        req;
  logic        isStore;
  logic        isLoad;
  logic [1:0]  lane;
  logic [3:0]  be;
  regionT      region;
  logic        pushReq;
  logic        pop;
  logic        fifoFull;
  logic        fifoEmpty;
  logic [31:0] statusWord;
  logic [31:0] uartRdWord;

  logic        ldPendQ;
  logic        misQ;
  logic        byteQ;
  logic        halfQ;
  logic        unsQ;
  logic [1:0]  laneQ;
  regionT      regionQ;
  logic [31:0] uartWordQ;
  logic        ovfQ;

  logic        unusedSink;

  // Mode priority byte > half > word keeps a malformed RamMode well defined.
  assign isByte     = RamMode[ModeByte];
  assign isHalf     = ~isByte & RamMode[ModeHalf];
  assign isUnsigned = RamMode[ModeUnsigned];
  assign lane       = isByte ? addr[1:0] : (isHalf ? {addr[1], 1'b0} : 2'b00);

`ifdef DBUS_MISALIGN_CHECK_EN
  assign aligned = isByte | (isHalf ? ~addr[0] : (addr[1:0] == 2'b00));
`else
  assign aligned = 1'b1;
`endif

  assign region  = (addr[31:28] == UART_BASE[31:28]) ? REG_UART : REG_RAM;
  assign req     = clkEn & rstB & (wrEn | rdEn);
  assign isStore = req & aligned & wrEn;
  // Misaligned loads still complete, returning zero data.
  assign isLoad  = req & ~wrEn;

  assign be        = isByte ? (4'b0001 << lane) : (isHalf ? (4'b0011 << lane) : 4'b1111);
  assign ram_addr  = addr[RAM_AW+1:2];
  assign ram_wdata = isByte ? {4{dataBusOut[7:0]}} :
                     (isHalf ? {2{dataBusOut[15:0]}} : dataBusOut);
  assign ram_we    = isStore & (region == REG_RAM);
  assign ram_re    = isLoad & aligned & (region == REG_RAM);
  assign ram_be    = (ram_we | ram_re) ? be : 4'b0000;

  assign pushReq  = isStore & (region == REG_UART) & (addr[3:0] == TXDATA);
  assign pop      = tx_valid & tx_ready;
  assign tx_valid = ~fifoEmpty;

  dbus_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) uTxFifo (
    .clk     (clk),
    .rstB    (rstB),
    .push    (pushReq),
    .pushData(dataBusOut[7:0]),
    .pop     (pop),
    .head    (tx_data),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

  always_comb begin
    statusWord               = '0;
    statusWord[StatFull]     = fifoFull;
    statusWord[StatEmpty]    = fifoEmpty;
    statusWord[StatMisalign] = err_misalign;
    statusWord[StatOverflow] = ovfQ;
    uartRdWord               = (addr[3:0] == STATUS) ? statusWord : '0;
  end

  always_ff @(posedge clk) begin
    if (!rstB) begin
      ldPendQ   <= 1'b0;
      misQ      <= 1'b0;
      byteQ     <= 1'b0;
      halfQ     <= 1'b0;
      unsQ      <= 1'b0;
      laneQ     <= 2'b00;
      regionQ   <= REG_RAM;
      uartWordQ <= '0;
      ovfQ      <= 1'b0;
    end else begin
      ldPendQ   <= isLoad;
      misQ      <= ~aligned;
      byteQ     <= isByte;
      halfQ     <= isHalf;
      unsQ      <= isUnsigned;
      laneQ     <= lane;
      regionQ   <= region;
      uartWordQ <= uartRdWord;
      if (pushReq & fifoFull & ~pop) ovfQ <= 1'b1;
    end
  end

`ifdef DBUS_MISALIGN_CHECK_EN
  logic errQ;
  always_ff @(posedge clk) begin
    if (!rstB) begin
      errQ <= 1'b0;
    end else if (req & ~aligned) begin
      errQ <= 1'b1;
    end
  end
  assign err_misalign = errQ;
`else
  assign err_misalign = 1'b0;
`endif

  // Gating with rstB discards a load whose return cycle coincides with reset.
  assign dataBusInEn = ldPendQ & rstB;

  always_comb begin
    dataBusIn = '0;
    if (dataBusInEn && !misQ) begin
      dataBusIn = (regionQ == REG_UART) ? uartWordQ :
                  alignLoad(ram_rdata, laneQ, byteQ, halfQ, unsQ);
    end
  end

  assign unusedSink = ^{addr[27:4], RamMode[ModeWord]};

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Self-checking bench for data_bus_ctrl: directed test-plan steps, then randomized traffic
// checked against a byte-level reference model. Honours DBUS_MISALIGN_CHECK_EN.
module tb_data_bus_ctrl;

  localparam int unsigned Depth = 8;
  localparam logic [3:0] MB = 4'b1000;
  localparam logic [3:0] MH = 4'b0100;
  localparam logic [3:0] MW = 4'b0010;
  localparam logic [3:0] MU = 4'b0001;
`ifdef DBUS_MISALIGN_CHECK_EN
  localparam logic [31:0] MisBit = 32'h4;
`else
  localparam logic [31:0] MisBit = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rstB, clkEn, wrEn, rdEn, tx_ready;
  logic [31:0] addr, dataBusOut, ram_rdata;
  logic [3:0]  RamMode;
  logic [31:0] dataBusIn, ram_wdata;
  logic        dataBusInEn, ram_we, ram_re, tx_valid, err_misalign;
  logic [11:0] ram_addr;
  logic [3:0]  ram_be;
  logic [7:0]  tx_data;

  int nCmp = 0;
  int nErr = 0;

  // Reference model state
  logic [7:0]  q[$];
  bit          ovf, err;
  bit          pValid, pMis, pUart, pUns;
  int          pOff, pSize;
  logic [31:0] pUartWord;
  logic [7:0]  drainList[8];

  data_bus_ctrl dut (
    .clk(clk), .rstB(rstB), .clkEn(clkEn), .addr(addr), .dataBusOut(dataBusOut),
    .wrEn(wrEn), .rdEn(rdEn), .RamMode(RamMode), .dataBusIn(dataBusIn),
    .dataBusInEn(dataBusInEn), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be),
    .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .err_misalign(err_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit c, input bit w, input bit r, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] d);
    clkEn = c; wrEn = w; rdEn = r; addr = a; RamMode = m; dataBusOut = d;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 32'h0, MW, 32'h0);
  endtask

  // Check all outputs against the model for the current cycle, then advance one clock.
  task automatic cycle();
    int n, off;
    bit aligned, isUart, req, store, load, popN, pushAtt, full, expWe, expRe, expEn;
    logic [31:0] expBe, expWd, expData, mask, v, statusW;
    #1;
    n = RamMode[3] ? 1 : (RamMode[2] ? 2 : 4);
    isUart = (addr[31:28] == 4'h1);
`ifdef DBUS_MISALIGN_CHECK_EN
    aligned = ((addr % n) == 0);
`else
    aligned = 1'b1;
`endif
    off   = int'((addr % 4) / n) * n;
    req   = clkEn && rstB && (wrEn || rdEn);
    store = req && wrEn && aligned;
    load  = req && !wrEn;
    expWe = store && !isUart;
    expRe = load && aligned && !isUart;
    expBe = (expWe || expRe) ? (((32'd1 << n) - 1) << off) : 32'h0;
    for (int i = 0; i < 4; i++) expWd[8*i +: 8] = dataBusOut[8*(i % n) +: 8];
    chk("ram_we", ram_we, expWe);
    chk("ram_re", ram_re, expRe);
    chk("ram_be", ram_be, expBe);
    chk("ram_addr", ram_addr, (addr >> 2) & 32'hFFF);
    if (expWe) chk("ram_wdata", ram_wdata, expWd);

    expEn = pValid && rstB;
    if (!expEn || pMis) expData = 32'h0;
    else if (pUart) expData = pUartWord;
    else begin
      mask = (pSize == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * pSize)) - 1);
      v = (ram_rdata >> (8 * pOff)) & mask;
      if (!pUns && pSize < 4 && v[8*pSize-1]) v = v | ~mask;
      expData = v;
    end
    chk("dataBusInEn", dataBusInEn, expEn);
    chk("dataBusIn", dataBusIn, expData);
    chk("tx_valid", tx_valid, q.size() > 0);
    chk("tx_data", tx_data, (q.size() > 0) ? q[0] : 8'h00);
    chk("err_misalign", err_misalign, err);

    full    = (q.size() == Depth);
    statusW = {28'b0, ovf, err, q.size() == 0, full};
    popN    = (q.size() > 0) && tx_ready;
    pushAtt = store && isUart && (addr[3:0] == 4'h0);
    @(posedge clk);
    if (!rstB) begin
      q.delete(); ovf = 0; err = 0; pValid = 0;
    end else begin
      if (req && !aligned) err = 1;
      if (popN) void'(q.pop_front());
      if (pushAtt) begin
        if (!full || popN) q.push_back(dataBusOut[7:0]);
        else ovf = 1;
      end
      pValid = load; pMis = !aligned; pUart = isUart; pOff = off; pSize = n;
      pUns = RamMode[0];
      pUartWord = (isUart && addr[3:0] == 4'h4) ? statusW : 32'h0;
    end
    #1;
  endtask

  initial begin
    drainList = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    rstB = 1'b0; tx_ready = 1'b0; ram_rdata = 32'h0;
    idle();
    @(posedge clk); #1;
    chk("rst_en", dataBusInEn, 32'h0);
    chk("rst_be", ram_be, 32'h0);
    chk("rst_txv", tx_valid, 32'h0);
    cycle();
    cycle();
    rstB = 1'b1;

    // Byte store, then LB / LBU of the same lane
    drive(1, 1, 0, 32'h3, MB, 32'hA5);
    #1;
    chk("sb_be", ram_be, 32'h8);
    chk("sb_wdata", ram_wdata, 32'hA5A5_A5A5);
    cycle();
    drive(1, 0, 1, 32'h3, MB, 32'h0);
    cycle();
    ram_rdata = 32'hA500_0000;
    drive(1, 0, 1, 32'h3, MB | MU, 32'h0);
    #1 chk("lb", dataBusIn, 32'hFFFF_FFA5);
    cycle();
    idle();
    #1 chk("lbu", dataBusIn, 32'h0000_00A5);
    cycle();

    // Back-to-back halfword loads
    ram_rdata = 32'h8001_7F00;
    drive(1, 0, 1, 32'h2, MH, 32'h0);
    cycle();
    drive(1, 0, 1, 32'h0, MH | MU, 32'h0);
    #1 chk("lh", dataBusIn, 32'hFFFF_8001);
    cycle();
    idle();
    #1 chk("lhu", dataBusIn, 32'h0000_7F00);
    cycle();

    // Word load at 0x2
    drive(1, 0, 1, 32'h2, MW, 32'h0);
`ifdef DBUS_MISALIGN_CHECK_EN
    #1 chk("mis_re", ram_re, 32'h0);
`endif
    cycle();
    idle();
`ifdef DBUS_MISALIGN_CHECK_EN
    #1;
    chk("mis_en", dataBusInEn, 32'h1);
    chk("mis_data", dataBusIn, 32'h0);
`endif
    cycle();
    cycle();
    chk("mis_sticky", err_misalign, MisBit >> 2);

    // Fill the TX FIFO, overflow it, then push while full with a pop
    for (int i = 1; i <= 8; i++) begin
      drive(1, 1, 0, 32'h1000_0000, MB, i);
      cycle();
    end
    drive(1, 0, 1, 32'h1000_0004, MW, 32'h0);
    cycle();
    idle();
    #1 chk("stat_full", dataBusIn, 32'h1 | MisBit);
    cycle();
    drive(1, 1, 0, 32'h1000_0000, MB, 32'h09);
    cycle();
    drive(1, 0, 1, 32'h1000_0004, MW, 32'h0);
    cycle();
    idle();
    #1 chk("stat_ovf", dataBusIn, 32'h9 | MisBit);
    cycle();
    tx_ready = 1'b1;
    drive(1, 1, 0, 32'h1000_0000, MB, 32'h0A);
    #1 chk("head_first", tx_data, 32'h01);
    cycle();
    idle();
    for (int k = 0; k < 8; k++) begin
      #1 chk("drain", tx_data, drainList[k]);
      cycle();
    end
    #1 chk("drained", tx_valid, 32'h0);
    tx_ready = 1'b0;
    drive(1, 0, 1, 32'h1000_0004, MW, 32'h0);
    cycle();
    idle();
    #1 chk("stat_empty", dataBusIn, 32'hA | MisBit);
    cycle();

    // clkEn low suppresses stores
    drive(0, 1, 0, 32'h100, MW, 32'hDEAD_BEEF);
    #1 chk("clken_we", ram_we, 32'h0);
    cycle();
    drive(0, 1, 0, 32'h1000_0000, MB, 32'h55);
    cycle();
    idle();
    #1 chk("clken_push", tx_valid, 32'h0);
    cycle();

    // Reset during a pending load
    drive(1, 0, 1, 32'h0, MW, 32'h0);
    cycle();
    rstB = 1'b0;
    idle();
    #1 chk("rst_pend", dataBusInEn, 32'h0);
    cycle();
    rstB = 1'b1;
    #1 chk("rst_after", dataBusInEn, 32'h0);
    cycle();

    // Randomized traffic
    for (int it = 0; it < 600; it++) begin
      logic [31:0] a;
      logic [3:0] m;
      rstB = ($urandom_range(0, 60) != 0);
      tx_ready = $urandom_range(0, 1);
      ram_rdata = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        a = 32'h1000_0000 | (32'h4 * $urandom_range(0, 2)) | $urandom_range(0, 1);
      end else begin
        a = $urandom;
        if (a[31:28] == 4'h1) a[31:28] = 4'h0;
      end
      case ($urandom_range(0, 2))
        0: m = MB;
        1: m = MH;
        default: m = MW;
      endcase
      if ($urandom_range(0, 1) == 1) m = m | MU;
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 1), a, m,
            $urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
